multicycle_core: RTL and testbench
==================================

# multicycle_core

Parametrised multi-cycle RISC-V (RV32I subset) core; next generation of the single-cycle core. Executes one instruction over 3–5 states through an FSM and a single shared memory port with a ready handshake, so text and data live in one external memory of configurable depth. Adds addi/bne/jal, illegal-instruction trapping, run/halt control (replacing the button-clock scheme) and a registered LED debug fold. Sits between the board top and a unified memory block.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_ADDR_WIDTH, 10, word-address width of the memory port (depth 2^MEM_ADDR_WIDTH words).
- LED_WIDTH, 8, width of the debug fold output; must divide 32.
- clk  in  1  single core clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; a new instruction fetch starts only while high.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write (sw), 0 = read (fetch/lw); valid with mem_req.
- mem_addr  out  MEM_ADDR_WIDTH  word address (byte address [MEM_ADDR_WIDTH+1:2]).
- mem_wdata  out  32  store data; valid with mem_req & mem_we.
- mem_rdata  in  32  read data; sampled in the cycle mem_ready=1.
- mem_ready  in  1  completes the current request this cycle.
- pc  out  32  current program counter.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky; set on trap.
- leds  out  LED_WIDTH  OR-fold of the last register writeback value.

## Operation
- Supported: lw, sw, beq, bne, add, sub, and, or, addi, jal. Any other opcode/funct3/funct7 combination traps.
- Internal 32x32 register file, x0 hardwired zero (writes dropped); two async read ports, one sync write port.
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH: if run=1 and not halted, mem_req=1, mem_we=0, mem_addr=pc word; on mem_ready latch IR <- mem_rdata -> DECODE. If run=0, no request, stay.
- DECODE: latch A <- rs1, B <- rs2, IMM <- sign-extended immediate (I/S/B/J formats); illegal -> TRAP.
- EXECUTE: ALUOUT <- result. R-type/addi -> WB. lw/sw: address = rs1+imm; if address[1:0]!=0 -> TRAP, else -> MEM. beq/bne: pc <- taken ? pc+imm : pc+4, retire, -> FETCH. jal: rd <- pc+4 (x0 dropped), pc <- pc+imm, retire, -> FETCH.
- MEM: mem_req=1, mem_we=(sw), mem_wdata=B; hold until mem_ready. lw -> WB with MDR <- mem_rdata; sw: pc <- pc+4, retire, -> FETCH.
- WB: rd <- (lw ? MDR : ALUOUT); pc <- pc+4; retire; -> FETCH.
- TRAP: halted=1, no requests; pc holds address of the faulting instruction; left only by rst.
- All arithmetic modulo 2^32; branch/jal targets not alignment-checked beyond bit 0 cleared... targets with [1:0]!=0 trap on the following fetch.
- leds[i] = OR over k of wdata[i + k*LED_WIDTH] of the last register-file write (including x0-targeted writes excluded: leds update only on real writes); registered.
- run deasserted mid-instruction: current instruction completes; stall only at next FETCH.

## Timing
- Reset (any state, including mid-request): next edge -> FETCH, pc=RESET_PC, all registers x1–x31=0, mem_req=0, mem_we=0, mem_wdata=0, retire=0, halted=0, leds=0.
- Zero-wait memory (mem_ready same cycle as mem_req): R-type/addi 4 cycles, lw 5, sw 4, beq/bne/jal 3. Each memory wait cycle adds 1.
- mem_req, mem_we, mem_addr, mem_wdata registered-stable for the whole request; deassert the cycle after mem_ready unless a new request follows.
- retire asserts in the cycle the pc update is registered; pc changes on the same edge.
- halted rises on the edge entering TRAP and stays until rst.

## Test plan
- Reset then run=1, zero-wait mem with addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12, leds=8'h0C, 3 retire pulses at cycles 4/8/12, pc=0x0C.
- sw x3,8(x0) then lw x4,8(x0), mem_ready delayed 2 cycles per request -> write at word 2 data 12; x4=12; lw takes 5+4 wait cycles; mem_req held stable throughout.
- beq x1,x1,-8 taken and bne x1,x1,+8 not taken -> pc decreases by 8; then pc+4; each 3 cycles; jal x5,16 at pc=0x20 -> x5=0x24, pc=0x30.
- Illegal word 32'hFFFF_FFFF at pc=0x10, and lw with address 0x6 -> halted=1, pc=0x10 (resp. lw address), no further mem_req.
- run=0 during EXECUTE of add -> instruction retires, then no mem_req until run=1.
- rst asserted while mem_req pending in MEM -> next edge mem_req=0, pc=RESET_PC, x1..x31=0, halted=0.

Source files
------------

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core (lw/sw/beq/bne/add/sub/and/or/addi/jal) sharing one
// memory port between fetch and data, with run/halt control and an LED debug fold.
module multicycle_core #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned LED_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ready,
    output logic [31:0]               pc,
    output logic                      retire,
    output logic                      halted,
    output logic [LED_WIDTH-1:0]      leds
);

    localparam int unsigned FOLDS = 32 / LED_WIDTH;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_ADDI,
        OP_LW,
        OP_SW,
        OP_BEQ,
        OP_BNE,
        OP_JAL,
        OP_ILL
    } op_t;

    state_t state, state_next;

    logic [31:0] ir, a_reg, b_reg, imm_reg, alu_out, mdr;
    op_t         op_reg;
    logic [31:0] rf [32];

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    op_t         dec_op;
    logic [31:0] dec_imm;

    // Opcode/funct decode; anything unmatched stays OP_ILL and traps
    always_comb begin
        dec_op = OP_ILL;
        case (opcode)
            7'b0000011: if (funct3 == 3'b010) dec_op = OP_LW;
            7'b0100011: if (funct3 == 3'b010) dec_op = OP_SW;
            7'b0010011: if (funct3 == 3'b000) dec_op = OP_ADDI;
            7'b1101111: dec_op = OP_JAL;
            7'b1100011: begin
                if (funct3 == 3'b000)      dec_op = OP_BEQ;
                else if (funct3 == 3'b001) dec_op = OP_BNE;
            end
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = OP_ADD;
                    10'b0100000_000: dec_op = OP_SUB;
                    10'b0000000_111: dec_op = OP_AND;
                    10'b0000000_110: dec_op = OP_OR;
                    default:         dec_op = OP_ILL;
                endcase
            end
            default: dec_op = OP_ILL;
        endcase

        case (dec_op)
            OP_LW, OP_ADDI:  dec_imm = imm_i;
            OP_SW:           dec_imm = imm_s;
            OP_BEQ, OP_BNE:  dec_imm = imm_b;
            OP_JAL:          dec_imm = imm_j;
            default:         dec_imm = 32'h0;
        endcase
    end

    logic [31:0] alu_res, pc_plus4, pc_target;
    logic        br_taken;

    assign pc_plus4  = pc + 32'd4;
    assign pc_target = pc + imm_reg;

    always_comb begin
        case (op_reg)
            OP_ADD:              alu_res = a_reg + b_reg;
            OP_SUB:              alu_res = a_reg - b_reg;
            OP_AND:              alu_res = a_reg & b_reg;
            OP_OR:               alu_res = a_reg | b_reg;
            OP_ADDI, OP_LW, OP_SW: alu_res = a_reg + imm_reg;
            default:             alu_res = 32'h0;
        endcase
        br_taken = (op_reg == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
    end

    function automatic logic [LED_WIDTH-1:0] fold(input logic [31:0] w);
        logic [LED_WIDTH-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < FOLDS; k++) begin
            r |= w[k*LED_WIDTH +: LED_WIDTH];
        end
        return r;
    endfunction

    logic                      req_next, we_next, retire_next, halted_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_next;
    logic [31:0]               wdata_next, pc_next, rf_wdata, fetch_target;
    logic                      ir_load, dec_load, alu_load, mdr_load, rf_we, to_fetch;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next state plus next values of every registered output and datapath strobe
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        req_next     = mem_req;
        we_next      = mem_we;
        addr_next    = mem_addr;
        wdata_next   = mem_wdata;
        retire_next  = 1'b0;
        halted_next  = halted;
        ir_load      = 1'b0;
        dec_load     = 1'b0;
        alu_load     = 1'b0;
        mdr_load     = 1'b0;
        rf_we        = 1'b0;
        rf_wdata     = alu_out;
        to_fetch     = 1'b0;
        fetch_target = pc_plus4;

        case (state)
            S_FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    state_next  = S_TRAP;
                    halted_next = 1'b1;
                    req_next    = 1'b0;
                end else if (mem_req) begin
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        req_next   = 1'b0;
                        state_next = S_DECODE;
                    end
                end else if (run) begin
                    req_next  = 1'b1;
                    we_next   = 1'b0;
                    addr_next = pc[MEM_ADDR_WIDTH+1:2];
                end
            end
            S_DECODE: begin
                if (dec_op == OP_ILL) begin
                    state_next  = S_TRAP;
                    halted_next = 1'b1;
                end else begin
                    dec_load   = 1'b1;
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_load = 1'b1;
                case (op_reg)
                    OP_LW, OP_SW: begin
                        if (alu_res[1:0] != 2'b00) begin
                            state_next  = S_TRAP;
                            halted_next = 1'b1;
                        end else begin
                            state_next = S_MEM;
                            req_next   = 1'b1;
                            we_next    = (op_reg == OP_SW);
                            addr_next  = alu_res[MEM_ADDR_WIDTH+1:2];
                            if (op_reg == OP_SW) wdata_next = b_reg;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        to_fetch     = 1'b1;
                        fetch_target = br_taken ? pc_target : pc_plus4;
                    end
                    OP_JAL: begin
                        rf_we        = (rd != 5'd0);
                        rf_wdata     = pc_plus4;
                        to_fetch     = 1'b1;
                        fetch_target = pc_target;
                    end
                    default: state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_reg == OP_LW) begin
                        mdr_load   = 1'b1;
                        req_next   = 1'b0;
                        we_next    = 1'b0;
                        state_next = S_WB;
                    end else begin
                        to_fetch = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd != 5'd0);
                rf_wdata = (op_reg == OP_LW) ? mdr : alu_out;
                to_fetch = 1'b1;
            end
            S_TRAP: begin
                req_next = 1'b0;
                we_next  = 1'b0;
            end
            default: state_next = S_TRAP;
        endcase

        // Retire; the next fetch request is issued on the same edge to save a cycle
        if (to_fetch) begin
            state_next  = S_FETCH;
            pc_next     = fetch_target;
            retire_next = 1'b1;
            we_next     = 1'b0;
            req_next    = run && (fetch_target[1:0] == 2'b00);
            addr_next   = fetch_target[MEM_ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            retire    <= 1'b0;
            halted    <= 1'b0;
            leds      <= '0;
            ir        <= 32'h0;
            a_reg     <= 32'h0;
            b_reg     <= 32'h0;
            imm_reg   <= 32'h0;
            op_reg    <= OP_ILL;
            alu_out   <= 32'h0;
            mdr       <= 32'h0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            pc        <= pc_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            retire    <= retire_next;
            halted    <= halted_next;
            if (ir_load) ir <= mem_rdata;
            if (dec_load) begin
                a_reg   <= rf[rs1];
                b_reg   <= rf[rs2];
                imm_reg <= dec_imm;
                op_reg  <= dec_op;
            end
            if (alu_load) alu_out <= alu_res;
            if (mdr_load) mdr <= mem_rdata;
            if (rf_we) begin
                rf[rd] <= rf_wdata;
                leds   <= fold(rf_wdata);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: a behavioural unified memory with a programmable
// ready delay, plus short hand-assembled programs with hand-computed results.
module tb_multicycle_core;

    logic        clk, rst, run;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc;
    logic [7:0]  leds;

    multicycle_core #(
        .RESET_PC(32'h0000_0000),
        .MEM_ADDR_WIDTH(10),
        .LED_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc(pc),
        .retire(retire),
        .halted(halted),
        .leds(leds)
    );

    logic [31:0] mem [0:1023];
    int          ready_delay;
    int          stable_err;
    int          n_tests;
    int          n_fail;
    int          cycle;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Memory responder: acts at negedge, holds ready low for ready_delay cycles
    initial begin
        int          wcnt;
        logic [9:0]  lat_addr;
        logic        lat_we;
        logic [31:0] lat_wd;
        wcnt = 0; lat_addr = '0; lat_we = 1'b0; lat_wd = '0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req) begin
                if (wcnt == 0) begin
                    lat_addr = mem_addr; lat_we = mem_we; lat_wd = mem_wdata;
                end else if (mem_addr !== lat_addr || mem_we !== lat_we ||
                             (mem_we && mem_wdata !== lat_wd)) begin
                    stable_err++;
                end
                if (wcnt >= ready_delay) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic wait_retire(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (retire) ok = 1'b1;
        end
    endtask

    task automatic wait_halted(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (halted) ok = 1'b1;
        end
    endtask

    task automatic count_req(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (mem_req) hits++;
        end
    endtask

    initial begin
        logic ok;
        int   t_prev;
        int   hits;
        n_tests = 0; n_fail = 0; stable_err = 0; cycle = 0;
        rst = 1'b1; run = 1'b0; ready_delay = 0;

        // addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,8(x0); lw x4,8(x0)
        clear_mem();
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0070_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0030_2423;
        mem[4] = 32'h0080_2203;
        repeat (2) @(negedge clk);
        check("reset pc", pc, 32'h0);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_we", 32'(mem_we), 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset retire", 32'(retire), 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        check("reset leds", 32'(leds), 32'h0);

        rst = 1'b0; run = 1'b1;
        wait_retire(50, ok);
        check("addi1 retired", 32'(ok), 32'h1);
        t_prev = cycle;
        check("addi1 pc", pc, 32'h4);
        check("addi1 leds", 32'(leds), 32'h05);
        wait_retire(20, ok);
        check("addi2 interval", 32'(cycle - t_prev), 32'd4);
        t_prev = cycle;
        check("addi2 pc", pc, 32'h8);
        check("addi2 leds", 32'(leds), 32'h07);
        // two negedges later the add is in EXECUTE
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        wait_retire(20, ok);
        check("add interval", 32'(cycle - t_prev), 32'd4);
        check("add pc", pc, 32'hC);
        check("add leds", 32'(leds), 32'h0C);
        count_req(8, hits);
        check("run low no req", 32'(hits), 32'h0);

        ready_delay = 2; run = 1'b1;
        wait_retire(60, ok);
        check("sw retired", 32'(ok), 32'h1);
        t_prev = cycle;
        check("sw pc", pc, 32'h10);
        check("sw mem[2]", mem[2], 32'd12);
        wait_retire(60, ok);
        check("lw interval", 32'(cycle - t_prev), 32'd9);
        check("lw pc", pc, 32'h14);
        check("lw leds", 32'(leds), 32'h0C);
        check("req stable", 32'(stable_err), 32'h0);

        // Control flow, reset-cleared x1 store, and a misaligned lw trap
        rst = 1'b1; run = 1'b0; ready_delay = 0;
        clear_mem();
        mem[0]  = 32'h0100_006F;  // 0x00 jal x0,+16
        mem[2]  = 32'h0010_9463;  // 0x08 bne x1,x1,+8
        mem[3]  = 32'h0140_006F;  // 0x0C jal x0,+20
        mem[4]  = 32'hFE10_8CE3;  // 0x10 beq x1,x1,-8
        mem[8]  = 32'h0100_02EF;  // 0x20 jal x5,+16
        mem[12] = 32'h0450_2023;  // 0x30 sw x5,0x40(x0)
        mem[13] = 32'h0410_2223;  // 0x34 sw x1,0x44(x0)
        mem[14] = 32'h0060_2203;  // 0x38 lw x4,6(x0)
        mem[17] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1;
        wait_retire(50, ok);
        t_prev = cycle;
        check("jal x0 pc", pc, 32'h10);
        check("jal x0 leds", 32'(leds), 32'h0);
        wait_retire(20, ok);
        check("beq interval", 32'(cycle - t_prev), 32'd3);
        t_prev = cycle;
        check("beq taken pc", pc, 32'h08);
        wait_retire(20, ok);
        check("bne interval", 32'(cycle - t_prev), 32'd3);
        check("bne fallthrough pc", pc, 32'h0C);
        wait_retire(20, ok);
        t_prev = cycle;
        check("jal x0 #2 pc", pc, 32'h20);
        wait_retire(20, ok);
        check("jal x5 interval", 32'(cycle - t_prev), 32'd3);
        check("jal x5 pc", pc, 32'h30);
        check("jal x5 leds", 32'(leds), 32'h24);
        wait_retire(20, ok);
        check("sw x5 data", mem[16], 32'h24);
        wait_retire(20, ok);
        check("x1 cleared by reset", mem[17], 32'h0);
        wait_halted(20, ok);
        check("misaligned lw halted", 32'(ok), 32'h1);
        check("misaligned lw pc", pc, 32'h38);
        count_req(6, hits);
        check("trap no req", 32'(hits), 32'h0);

        // Illegal instruction at 0x10 after four nops
        rst = 1'b1; run = 1'b0;
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;
        mem[4] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check("halted cleared", 32'(halted), 32'h0);
        rst = 1'b0; run = 1'b1;
        wait_halted(60, ok);
        check("illegal halted", 32'(ok), 32'h1);
        check("illegal pc", pc, 32'h10);
        count_req(6, hits);
        check("illegal no req", 32'(hits), 32'h0);

        // Reset while a store is waiting in MEM
        rst = 1'b1; run = 1'b0; ready_delay = 20;
        clear_mem();
        mem[0] = 32'h0050_0093;   // addi x1,x0,5
        mem[1] = 32'h0410_2023;   // sw x1,0x40(x0)
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) ok = 1'b1;
        end
        check("store pending", 32'(ok), 32'h1);
        check("store wdata", mem_wdata, 32'h5);
        check("pre-reset leds", 32'(leds), 32'h05);
        rst = 1'b1;
        @(negedge clk);
        check("mid-req rst mem_req", 32'(mem_req), 32'h0);
        check("mid-req rst mem_we", 32'(mem_we), 32'h0);
        check("mid-req rst wdata", mem_wdata, 32'h0);
        check("mid-req rst pc", pc, 32'h0);
        check("mid-req rst leds", 32'(leds), 32'h0);
        ready_delay = 0;
        clear_mem();
        mem[0]  = 32'h0410_2223;  // sw x1,0x44(x0)
        mem[1]  = 32'hFFFF_FFFF;
        mem[17] = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        wait_halted(60, ok);
        check("post-rst halted", 32'(ok), 32'h1);
        check("post-rst x1 zero", mem[17], 32'h0);
        check("post-rst trap pc", pc, 32'h4);
        check("req stable all", 32'(stable_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
